// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates core fetch and data ports onto one memory bus with timeout
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       grant_dm, grant_if, acked, timed_out;

  always_comb begin
    state_next = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    acked      = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req) begin
          grant_dm   = 1'b1;
          state_next = DATA;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH, DATA: begin
        // an ack on the final wait cycle still completes normally
        if (bus_ack) begin
          acked      = 1'b1;
          state_next = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= 4'h0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      if_rdata   <= 32'h0;
      if_valid   <= 1'b0;
      dm_rdata   <= 32'h0;
      dm_valid   <= 1'b0;
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      state    <= state_next;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      fault    <= 1'b0;
      if (grant_dm) begin
        bus_req   <= 1'b1;
        bus_we    <= dm_we;
        bus_be    <= dm_be;
        bus_addr  <= dm_addr;
        bus_wdata <= dm_wdata;
        wait_cnt  <= 8'd0;
      end else if (grant_if) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b0;
        bus_be    <= 4'hF;
        bus_addr  <= if_addr;
        bus_wdata <= 32'h0;
        wait_cnt  <= 8'd0;
      end
      if (acked) begin
        bus_req <= 1'b0;
        if (state == FETCH) begin
          if_rdata <= bus_rdata;
          if_valid <= 1'b1;
        end else begin
          dm_valid <= 1'b1;
          if (!bus_we) dm_rdata <= bus_rdata;
        end
      end else if (timed_out) begin
        bus_req    <= 1'b0;
        fault      <= 1'b1;
        fault_addr <= bus_addr;
      end else if (state == FETCH || state == DATA) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign stall = ((dm_req & ~dm_valid) | (if_req & ~if_valid)) & ~fault;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, bus wait-cycle limit before fault (legal 1..255).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: if_req  input  1  instruction-fetch request, held until if_valid or fault.
REQ-005 SHALL have port: if_addr  input  32  fetch address.
REQ-006 SHALL have ports: if_rdata  output  32  fetched word; if_valid  output  1  one-cycle completion pulse.
REQ-007 SHALL have ports: dm_req  input  1 (held until dm_valid or fault); dm_we  input  1  store when 1; dm_be  input  4  byte enables; dm_addr  input  32; dm_wdata  input  32.
REQ-008 SHALL have ports: dm_rdata  output  32  load data; dm_valid  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: bus_req, bus_we  output  1 each; bus_be  output  4; bus_addr, bus_wdata  output  32 each; bus_ack  input  1; bus_rdata  input  32.
REQ-010 SHALL have ports: stall  output  1  core PC/regfile hold; fault  output  1  one-cycle timeout pulse; fault_addr  output  32  address of timed-out access.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DATA, RESP; all outputs except stall registered.
REQ-012 IDLE: dm_req=1 -> DATA; else if_req=1 -> FETCH; else stay; data has fixed priority over fetch.
REQ-013 On grant, SHALL latch address/we/be/wdata of the winner into bus_* and assert bus_req from the next cycle; fetch grants drive bus_we=0, bus_be=4'hF, bus_wdata=0.
REQ-014 bus_* outputs SHALL stay constant while in FETCH/DATA; requester input changes after grant are ignored.
REQ-015 FETCH/DATA with bus_ack=1 -> RESP; bus_req deasserts same edge; bus_ack in the first bus_req cycle is valid (minimum latency: request in IDLE cycle N, valid in cycle N+2).
REQ-016 On FETCH ack: if_rdata <= bus_rdata, if_valid=1 during RESP.
REQ-017 On DATA ack: dm_valid=1 during RESP; dm_rdata <= bus_rdata for loads only, holds previous value for stores.
REQ-018 RESP SHALL last exactly one cycle, grant nothing, then -> IDLE; requester must drop or replace its request before the next IDLE cycle.
REQ-019 8-bit wait counter SHALL clear on grant, increment each FETCH/DATA cycle without ack.
REQ-020 Counter reaching TIMEOUT-1 with no ack -> IDLE, bus_req deasserted, fault=1 for one cycle, fault_addr <= bus_addr, no valid pulse.
REQ-021 bus_ack on the timeout cycle SHALL win: normal completion, no fault.
REQ-022 bus_ack while in IDLE or RESP SHALL be ignored.
REQ-023 stall (combinational) = (dm_req & ~dm_valid) | (if_req & ~if_valid), forced 0 in a fault cycle.
REQ-024 A request arriving in RESP SHALL wait for IDLE; priority re-evaluated there.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, counter 0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, fault=0, fault_addr=0.
REQ-026 reset mid-transaction SHALL abandon it with no valid or fault pulse; any later bus_ack ignored.

Verification
REQ-027 if_req=1, if_addr=0x100, bus_ack on first bus_req cycle with bus_rdata=0x00000013 -> bus_addr=0x100, if_valid pulse at N+2, if_rdata=0x00000013, stall low after pulse.
REQ-028 dm_req and if_req both 1 in IDLE (dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF, be=4'b0011) -> store issued first with bus_we=1, bus_be=4'b0011; fetch issued after RESP/IDLE; dm_rdata unchanged.
REQ-029 load at 0x3000, bus_ack after 5 wait cycles, bus_rdata=0x12345678 -> bus_* stable 6 cycles, dm_valid one pulse, dm_rdata=0x12345678.
REQ-030 TIMEOUT=4, fetch to 0x40 with no ack -> bus_req high 4 cycles, fault pulse, fault_addr=0x40, no if_valid; ack on 4th cycle instead -> if_valid, no fault.
REQ-031 reset asserted in 2nd DATA cycle, bus_ack next cycle -> all outputs at reset values, no dm_valid, FSM IDLE.
